// File: rtl/beam_thresh_loader.sv
// beam_thresh_loader: stages host-written per-beam thresholds and shifts them into the
// dual-beam trigger cascade, one write strobe per beam then a single update strobe.
module beam_thresh_loader #(
  parameter int          NBEAMS         = 2,
  parameter logic [17:0] DEFAULT_THRESH = 18'd4000,
  parameter string       AUTOLOAD       = "TRUE",
  localparam int         AW             = (NBEAMS > 1) ? $clog2(NBEAMS) : 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          thr_wr_i,
  input  logic          thr_set_i,
  input  logic [AW-1:0] thr_addr_i,
  input  logic [17:0]   thr_dat_i,
  input  logic [1:0]    load_i,
  output logic          busy_o,
  output logic          done_o,
  output logic [35:0]   thresh_o,
  output logic [1:0]    thresh_wr_o,
  output logic [1:0]    thresh_update_o
);
  typedef enum logic [1:0] {IDLE, SHIFT, UPDATE} state_t;
  localparam logic [AW:0]   NB       = (AW+1)'(NBEAMS);
  localparam logic [AW-1:0] LAST     = AW'(NBEAMS - 1);
  localparam logic [1:0]    PEND_RST = (AUTOLOAD == "TRUE") ? 2'b11 : 2'b00;
  state_t        state, state_n;
  logic [1:0]    act, act_n, pend, pend_n, req, wr_n, upd_n;
  logic [AW-1:0] idx, idx_n;
  logic [35:0]   th_n;
  logic [17:0]   stage [2][NBEAMS];
  logic          accept;
  assign req    = pend | load_i;
  assign accept = (state != SHIFT) && (|req);
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      for (int s = 0; s < 2; s++)
        for (int b = 0; b < NBEAMS; b++)
          stage[s][b] <= DEFAULT_THRESH;
    end else if (thr_wr_i && ({1'b0, thr_addr_i} < NB)) begin
      stage[thr_set_i][thr_addr_i] <= thr_dat_i;
    end
  // Beams go out highest index first so the first word reaches the far end of the cascade.
  always_comb begin
    act_n   = accept ? req : act;
    pend_n  = accept ? 2'b00 : req;
    idx_n   = accept ? LAST : ((state == SHIFT) ? idx - 1'b1 : idx);
    state_n = (state == SHIFT) ? ((idx == '0) ? UPDATE : SHIFT) : (accept ? SHIFT : IDLE);
    wr_n    = (state == SHIFT) ? act : 2'b00;
    upd_n   = (state == UPDATE) ? act : 2'b00;
    th_n    = '0;
    for (int k = 0; k < 2; k++)
      th_n[18*k +: 18] = (state == SHIFT && act[k]) ? stage[k][idx] : 18'd0;
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state           <= IDLE;
      act             <= '0;
      idx             <= '0;
      pend            <= PEND_RST;
      busy_o          <= 1'b0;
      done_o          <= 1'b0;
      thresh_o        <= '0;
      thresh_wr_o     <= '0;
      thresh_update_o <= '0;
    end else begin
      state           <= state_n;
      act             <= act_n;
      idx             <= idx_n;
      pend            <= pend_n;
      busy_o          <= state != IDLE;
      done_o          <= |thresh_update_o;
      thresh_o        <= th_n;
      thresh_wr_o     <= wr_n;
      thresh_update_o <= upd_n;
    end
endmodule
